// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : funct codes and enums shared by the multiply/divide unit
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    typedef enum logic {
        MUL = 1'b0,
        DIV = 1'b1
    } op_kind_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_div_step.sv
// ============================================================================
// muldiv_div_step : one combinational restoring-division step
// Revision        : 1.0
// ============================================================================
`default_nettype none

module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;

    assign w_shifted = {rem_i, bit_i};
    // When the subtraction is taken the true difference is below the divisor,
    // so the low WIDTH bits of the modular result are exact.
    assign w_diff    = w_shifted[WIDTH-1:0] - divisor_i;
    assign q_o       = (w_shifted >= {1'b0, divisor_i});
    assign rem_o     = q_o ? w_diff : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative multiply/divide with HI/LO registers and EX stall.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply. Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    op_kind_t           kind_q, kind_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               divzero_q, divzero_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic             w_start, w_mfhi, w_mflo, w_mthi, w_mtlo;
    logic             w_signed, w_sign_a, w_sign_b;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;
    logic [WIDTH-1:0] w_quot, w_rem;

    assign w_start = op_valid && (funct == FN_MULT || funct == FN_MULTU ||
                                  funct == FN_DIV  || funct == FN_DIVU);
    assign w_mfhi  = op_valid && (funct == FN_MFHI);
    assign w_mflo  = op_valid && (funct == FN_MFLO);
    assign w_mthi  = op_valid && (funct == FN_MTHI);
    assign w_mtlo  = op_valid && (funct == FN_MTLO);

    assign busy   = (state_q != IDLE);
    assign stall  = busy && (w_start || w_mfhi || w_mflo || w_mthi || w_mtlo);
    assign result = w_mfhi ? hi_q : (w_mflo ? lo_q : '0);
    assign hi     = hi_q;
    assign lo     = lo_q;

    assign w_signed = ~funct[0];
    assign w_sign_a = w_signed & rs_data[WIDTH-1];
    assign w_sign_b = w_signed & rt_data[WIDTH-1];
    assign w_a_mag  = w_sign_a ? (-rs_data) : rs_data;
    assign w_b_mag  = w_sign_b ? (-rt_data) : rt_data;

    // Multiply: upper half accumulates the multiplicand, whole product shifts right.
    assign w_mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                       (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // Divide: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient in.
    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (prod_q[2*WIDTH-1:WIDTH]),
        .bit_i     (prod_q[WIDTH-1]),
        .divisor_i (opnd_q),
        .rem_o     (w_rem_next),
        .q_o       (w_qbit)
    );

    assign w_quot = prod_q[WIDTH-1:0];
    assign w_rem  = prod_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`endif

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        divzero_d = divzero_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (w_start) begin
                    sign_a_d  = w_sign_a;
                    sign_b_d  = w_sign_b;
                    kind_d    = funct[1] ? DIV : MUL;
                    divzero_d = (rt_data == '0);
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = CALC;
                    if (funct[1]) begin
                        opnd_d = w_b_mag;
                        prod_d = {{WIDTH{1'b0}}, w_a_mag};
                    end else begin
                        opnd_d = w_a_mag;
                        prod_d = {{WIDTH{1'b0}}, w_b_mag};
`ifdef MULDIV_FAST_MUL_EN
                        prod_d  = w_fast_prod;
                        state_d = FIX;
`endif
                    end
                end
                if (w_mthi) begin
                    hi_d = rs_data;
                end
                if (w_mtlo) begin
                    lo_d = rs_data;
                end
            end
            CALC: begin
                if (kind_q == MUL) begin
                    prod_d = {w_mul_sum, prod_q[WIDTH-1:1]};
                end else begin
                    prod_d = {w_rem_next, prod_q[WIDTH-2:0], w_qbit};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (kind_q == MUL) begin
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? (-prod_q) : prod_q;
                end else begin
                    // A zero divisor leaves the dividend magnitude as remainder,
                    // so the normal remainder sign fix reproduces rs_data.
                    lo_d = divzero_q ? {WIDTH{1'b1}} :
                           ((sign_a_q ^ sign_b_q) ? (-w_quot) : w_quot);
                    hi_d = sign_a_q ? (-w_rem) : w_rem;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            kind_q    <= MUL;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            divzero_q <= 1'b0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            divzero_q <= divzero_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit (WIDTH=32)
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        stall;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;
    int cyc;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = 33;
`endif
    localparam int DIV_CYC = 33;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .funct    (funct),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .busy     (busy),
        .stall    (stall),
        .result   (result),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        op_valid = 1'b1; funct = f; rs_data = a; rt_data = b;
        @(negedge clk);
        op_valid = 1'b0; funct = 6'h00;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op_valid = 1'b0; funct = 6'h00; rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        check("multu_max_cyc", cyc, MUL_CYC);
        check("multu_max_hi", hi, 32'hFFFFFFFE);
        check("multu_max_lo", lo, 32'h00000001);

        run_op(FN_MULT, 32'hFFFFFFFD, 32'd7, cyc);
        check("mult_neg_cyc", cyc, MUL_CYC);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFEB);

        run_op(FN_MULTU, 32'h12345678, 32'h10, cyc);
        check("multu_carry_hi", hi, 32'h00000001);
        check("multu_carry_lo", lo, 32'h23456780);

        run_op(FN_DIV, 32'hFFFFFFF9, 32'd2, cyc);
        check("div_neg_cyc", cyc, DIV_CYC);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        run_op(FN_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
        check("div_min_lo", lo, 32'h80000000);
        check("div_min_hi", hi, 32'h0);

        run_op(FN_DIV, 32'd7, 32'hFFFFFFFE, cyc);
        check("div_negb_lo", lo, 32'hFFFFFFFD);
        check("div_negb_hi", hi, 32'h00000001);

        run_op(FN_DIVU, 32'd100, 32'd7, cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(FN_DIVU, 32'd5, 32'd0, cyc);
        check("divu_zero_lo", lo, 32'hFFFFFFFF);
        check("divu_zero_hi", hi, 32'h00000005);

        run_op(FN_DIV, 32'hFFFFFFFB, 32'd0, cyc);
        check("div_zero_lo", lo, 32'hFFFFFFFF);
        check("div_zero_hi", hi, 32'hFFFFFFFB);

        // mflo issued 3 cycles after a div start stalls until busy falls
        @(negedge clk);
        op_valid = 1'b1; funct = FN_DIV; rs_data = 32'd100; rt_data = 32'hFFFFFFF9;
        @(negedge clk);
        op_valid = 1'b0; funct = 6'h00;
        repeat (2) @(negedge clk);
        op_valid = 1'b1; funct = FN_MFLO;
        #1;
        check("mflo_stall", {31'b0, stall}, 32'd1);
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check("mflo_stall_cyc", cyc, 32'd31);
        check("mflo_result", result, 32'hFFFFFFF2);
        check("mflo_busy", {31'b0, busy}, 32'd0);
        check("div_stall_hi", hi, 32'd2);

        @(negedge clk);
        op_valid = 1'b1; funct = FN_MTHI; rs_data = 32'h1234;
        #1;
        check("mthi_nostall", {31'b0, stall}, 32'd0);
        check("mthi_not_yet", hi, 32'd2);
        @(negedge clk);
        funct = FN_MTLO; rs_data = 32'hABCD;
        #1;
        check("mthi_hi", hi, 32'h1234);
        @(negedge clk);
        funct = FN_MFHI;
        #1;
        check("mtlo_lo", lo, 32'hABCD);
        check("mfhi_result", result, 32'h1234);
        op_valid = 1'b0; funct = 6'h00;
        #1;
        check("idle_result", result, 32'h0);

        // asynchronous reset in the middle of a divu
        @(negedge clk);
        op_valid = 1'b1; funct = FN_DIVU; rs_data = 32'h1000; rt_data = 32'd3;
        @(negedge clk);
        op_valid = 1'b0; funct = 6'h00;
        repeat (9) @(negedge clk);
        #1;
        check("divu_midflight_busy", {31'b0, busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(FN_MULT, 32'd2, 32'd3, cyc);
        check("post_rst_cyc", cyc, MUL_CYC);
        check("post_rst_lo", lo, 32'd6);
        check("post_rst_hi", hi, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
